// File: rtl/pe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_pkg                                                          |
// | Brief    : Shared types and helpers for the PE output packer.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pe_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } pack_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Lowest bit of bit-plane `level` inside the packed output word.
    function automatic int plane_lsb(input int level, input int width);
        return level * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_plane_shiftreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_plane_shiftreg                                               |
// | Brief    : One bit-plane register with indexed bit write and clear.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pe_plane_shiftreg
    import pe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_wr_en,
    input  logic [clog2(WIDTH)-1:0]    i_wr_idx,
    input  logic                       i_wr_bit,
    output logic [WIDTH-1:0]           o_plane_next
);

    logic [WIDTH-1:0] r_plane;

    // The owner snapshots o_plane_next on the same edge it clears, so the
    // bit written in that cycle still makes it into the emitted word.
    always_comb begin
        o_plane_next = r_plane;
        if (i_wr_en) begin
            o_plane_next[i_wr_idx] = i_wr_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_plane <= '0;
        end else begin
            r_plane <= o_plane_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_output_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_output_packer                                                |
// | Brief    : Packs per-pixel multi-level bits bit-plane-wise into words and  |
// |            writes them to the next layer buffer with frame tracking.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pe_output_packer
    import pe_pkg::*;
#(
    parameter int BINARY_OUTPUT_LEVELS = 2,
    parameter int PACK_WIDTH           = 32,
    parameter int OUTPUT_ADDRESS       = 12,
    parameter int FRAME_PIXELS         = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       pixelValid,
    input  logic [BINARY_OUTPUT_LEVELS-1:0]            pixelBits,
    output logic                                       inReady,
    input  logic                                       flush,
    output logic                                       outValid,
    input  logic                                       outReady,
    output logic [BINARY_OUTPUT_LEVELS*PACK_WIDTH-1:0] outWord,
    output logic [OUTPUT_ADDRESS-1:0]                  outAddress,
    output logic                                       frameDone
);

    localparam int c_idx_w  = clog2(PACK_WIDTH);
    localparam int c_fill_w = c_idx_w + 1;
    localparam int c_pix_w  = clog2(FRAME_PIXELS + 1);
    localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(PACK_WIDTH);
    localparam logic [c_pix_w-1:0]  c_pix_end   = c_pix_w'(FRAME_PIXELS);

    pack_state_t                               r_state;
    logic [c_fill_w-1:0]                       r_fill_cnt;
    logic [c_pix_w-1:0]                        r_pix_cnt;
    logic                                      r_frame_end;

    logic                                      w_accept;
    logic                                      w_last_in_frame;
    logic                                      w_emit_go;
    logic [c_fill_w-1:0]                       w_fill_next;
    logic [c_pix_w-1:0]                        w_pix_next;
    logic [BINARY_OUTPUT_LEVELS*PACK_WIDTH-1:0] w_packed;

    // inReady is a register that is high exactly in FILL, so no path exists
    // from outReady to inReady.
    assign w_accept        = pixelValid & inReady;
    assign w_fill_next     = r_fill_cnt + c_fill_w'(w_accept);
    assign w_pix_next      = r_pix_cnt + c_pix_w'(w_accept);
    assign w_last_in_frame = w_accept && (w_pix_next == c_pix_end);
    assign w_emit_go       = (r_state == ST_FILL) &&
                             ((w_fill_next == c_fill_full) ||
                              w_last_in_frame ||
                              (flush && (w_fill_next != '0)));

    for (genvar l = 0; l < BINARY_OUTPUT_LEVELS; l++) begin : g_plane
        pe_plane_shiftreg #(
            .WIDTH (PACK_WIDTH)
        ) u_plane (
            .clk          (clk),
            .rst          (rst),
            .i_clr        (w_emit_go),
            .i_wr_en      (w_accept),
            .i_wr_idx     (r_fill_cnt[c_idx_w-1:0]),
            .i_wr_bit     (pixelBits[l]),
            .o_plane_next (w_packed[plane_lsb(l, PACK_WIDTH) +: PACK_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_fill_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_frame_end <= 1'b0;
            inReady     <= 1'b1;
            outValid    <= 1'b0;
            outWord     <= '0;
            outAddress  <= '0;
            frameDone   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    r_pix_cnt <= w_pix_next;
                    if (w_emit_go) begin
                        r_state     <= ST_EMIT;
                        r_fill_cnt  <= '0;
                        r_frame_end <= w_last_in_frame;
                        inReady     <= 1'b0;
                        outValid    <= 1'b1;
                        outWord     <= w_packed;
                    end else begin
                        r_fill_cnt <= w_fill_next;
                    end
                end
                ST_EMIT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        if (r_frame_end) begin
                            r_state    <= ST_DONE;
                            r_pix_cnt  <= '0;
                            outAddress <= '0;
                            frameDone  <= 1'b1;
                        end else begin
                            r_state    <= ST_FILL;
                            outAddress <= outAddress + OUTPUT_ADDRESS'(1);
                            inReady    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_FILL;
                    inReady <= 1'b1;
                end
                default: begin
                    r_state <= ST_FILL;
                    inReady <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_output_packer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench: instance A is the main 8x2 configuration, B has a 2-bit
// address space, C has a single-pixel frame.
module tb_pe_output_packer;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic        a_pv, a_flush, a_ordy, a_inr, a_ov, a_fd;
    logic [1:0]  a_bits;
    logic [15:0] a_word;
    logic [11:0] a_addr;

    logic        b_pv, b_flush, b_ordy, b_inr, b_ov, b_fd;
    logic [1:0]  b_bits;
    logic [15:0] b_word;
    logic [1:0]  b_addr;

    logic        c_pv, c_flush, c_ordy, c_inr, c_ov, c_fd;
    logic [1:0]  c_bits;
    logic [7:0]  c_word;
    logic [3:0]  c_addr;

    pe_output_packer #(.BINARY_OUTPUT_LEVELS(2), .PACK_WIDTH(8), .OUTPUT_ADDRESS(12), .FRAME_PIXELS(20)) u_dut_a (
        .clk(clk), .rst(rst), .pixelValid(a_pv), .pixelBits(a_bits), .inReady(a_inr), .flush(a_flush),
        .outValid(a_ov), .outReady(a_ordy), .outWord(a_word), .outAddress(a_addr), .frameDone(a_fd));

    pe_output_packer #(.BINARY_OUTPUT_LEVELS(2), .PACK_WIDTH(8), .OUTPUT_ADDRESS(2), .FRAME_PIXELS(48)) u_dut_b (
        .clk(clk), .rst(rst), .pixelValid(b_pv), .pixelBits(b_bits), .inReady(b_inr), .flush(b_flush),
        .outValid(b_ov), .outReady(b_ordy), .outWord(b_word), .outAddress(b_addr), .frameDone(b_fd));

    pe_output_packer #(.BINARY_OUTPUT_LEVELS(2), .PACK_WIDTH(4), .OUTPUT_ADDRESS(4), .FRAME_PIXELS(1)) u_dut_c (
        .clk(clk), .rst(rst), .pixelValid(c_pv), .pixelBits(c_bits), .inReady(c_inr), .flush(c_flush),
        .outValid(c_ov), .outReady(c_ordy), .outWord(c_word), .outAddress(c_addr), .frameDone(c_fd));

    // Transfer logs ({address, word}) and frameDone cycle counts.
    logic [27:0] a_xfer[$];
    logic [17:0] b_xfer[$];
    logic [11:0] c_xfer[$];
    int a_fd_cnt = 0;
    int b_fd_cnt = 0;
    int c_fd_cnt = 0;

    always @(posedge clk) begin
        if (!rst && a_ov && a_ordy) a_xfer.push_back({a_addr, a_word});
        if (!rst && b_ov && b_ordy) b_xfer.push_back({b_addr, b_word});
        if (!rst && c_ov && c_ordy) c_xfer.push_back({c_addr, c_word});
        if (a_fd) a_fd_cnt++;
        if (b_fd) b_fd_cnt++;
        if (c_fd) c_fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic pv, input logic [1:0] bits, input logic fl);
        case (d)
            0: begin a_pv = pv; a_bits = bits; a_flush = fl; end
            1: begin b_pv = pv; b_bits = bits; b_flush = fl; end
            default: begin c_pv = pv; c_bits = bits; c_flush = fl; end
        endcase
    endtask

    function automatic logic ready_of(input int d);
        case (d)
            0: return a_inr;
            1: return b_inr;
            default: return c_inr;
        endcase
    endfunction

    // Present one pixel and hold it until the packer takes it.
    task automatic send(input int d, input logic [1:0] bits, input logic fl);
        int budget;
        budget = 0;
        drive(d, 1'b1, bits, fl);
        while (!ready_of(d) && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: dut %0d inReady stayed 0, want 1", d);
        end
        tick();
        drive(d, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, 2'b00, 1'b0);
        drive(2, 1'b0, 2'b00, 1'b0);
        a_ordy = 1'b0; b_ordy = 1'b0; c_ordy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL reset_outValid: got %b want 0", a_ov); end
        n_cmp++; if (a_word !== 16'h0) begin n_err++; $display("FAIL reset_outWord: got %h want 0000", a_word); end
        n_cmp++; if (a_addr !== 12'h0) begin n_err++; $display("FAIL reset_outAddress: got %h want 000", a_addr); end
        n_cmp++; if (a_inr !== 1'b1) begin n_err++; $display("FAIL reset_inReady: got %b want 1", a_inr); end
        n_cmp++; if (a_fd !== 1'b0) begin n_err++; $display("FAIL reset_frameDone: got %b want 0", a_fd); end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic [15:0] exp_w [3] = '{16'hCCAA, 16'hCCAA, 16'h0C0A};
        logic [27:0] e;
        int start, fd0;
        do_reset();
        a_ordy = 1'b1;
        start = a_xfer.size();
        fd0 = a_fd_cnt;
        for (int i = 0; i < 20; i++) send(0, i[1:0], 1'b0);
        for (int t = 0; t < 20 && a_fd_cnt == fd0; t++) tick();
        repeat (3) tick();
        n_cmp++;
        if (a_xfer.size() - start != 3) begin
            n_err++; $display("FAIL frame_word_count: got %0d want 3", a_xfer.size() - start);
        end
        for (int k = 0; k < 3; k++) begin
            if (start + k < a_xfer.size()) begin
                e = a_xfer[start + k];
                n_cmp++;
                if (e !== {12'(k), exp_w[k]}) begin
                    n_err++; $display("FAIL frame_word%0d: got addr %h word %h want addr %h word %h", k, e[27:16], e[15:0], 12'(k), exp_w[k]);
                end
            end
        end
        n_cmp++; if (a_fd_cnt - fd0 != 1) begin n_err++; $display("FAIL frame_done_pulses: got %0d want 1", a_fd_cnt - fd0); end
        n_cmp++; if (a_addr !== 12'h0) begin n_err++; $display("FAIL frame_addr_after: got %h want 000", a_addr); end
        n_cmp++; if (a_inr !== 1'b1) begin n_err++; $display("FAIL frame_inReady_after: got %b want 1", a_inr); end
    endtask

    task automatic test_backpressure();
        logic [27:0] e;
        int start;
        do_reset();
        start = a_xfer.size();
        for (int i = 0; i < 8; i++) send(0, i[1:0], 1'b0);
        n_cmp++; if (a_ov !== 1'b1) begin n_err++; $display("FAIL bp_outValid_rise: got %b want 1", a_ov); end
        n_cmp++; if (a_word !== 16'hCCAA) begin n_err++; $display("FAIL bp_word0: got %h want ccaa", a_word); end
        a_pv = 1'b1;
        a_bits = 2'b00;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (a_ov !== 1'b1 || a_word !== 16'hCCAA || a_addr !== 12'h0 || a_inr !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got ov %b word %h addr %h inReady %b want 1 ccaa 000 0", c, a_ov, a_word, a_addr, a_inr);
            end
        end
        a_pv = 1'b0;
        a_ordy = 1'b1;
        tick();
        n_cmp++;
        if (a_xfer.size() - start != 1 || a_ov !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got xfers %0d ov %b want 1 0", a_xfer.size() - start, a_ov);
        end
        for (int i = 8; i < 16; i++) send(0, i[1:0], 1'b0);
        tick();
        n_cmp++;
        if (a_xfer.size() - start != 2) begin
            n_err++; $display("FAIL bp_word1_count: got %0d want 2", a_xfer.size() - start);
        end else begin
            e = a_xfer[start + 1];
            n_cmp++;
            if (e !== {12'h001, 16'hCCAA}) begin
                n_err++; $display("FAIL bp_word1: got addr %h word %h want addr 001 word ccaa", e[27:16], e[15:0]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        a_ordy = 1'b1;
        send(0, 2'b01, 1'b0);
        send(0, 2'b00, 1'b0);
        send(0, 2'b01, 1'b0);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        n_cmp++;
        if (a_ov !== 1'b1 || a_word !== 16'h0005 || a_addr !== 12'h0) begin
            n_err++; $display("FAIL flush_partial: got ov %b word %h addr %h want 1 0005 000", a_ov, a_word, a_addr);
        end
        tick();
        send(0, 2'b11, 1'b0);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        n_cmp++;
        if (a_ov !== 1'b1 || a_word !== 16'h0101 || a_addr !== 12'h001) begin
            n_err++; $display("FAIL flush_next_bit0: got ov %b word %h addr %h want 1 0101 001", a_ov, a_word, a_addr);
        end
        tick();
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        a_ordy = 1'b1;
        send(0, 2'b00, 1'b0);
        send(0, 2'b01, 1'b0);
        send(0, 2'b10, 1'b0);
        send(0, 2'b11, 1'b1);
        n_cmp++;
        if (a_ov !== 1'b1 || a_word !== 16'h0C0A || a_addr !== 12'h0) begin
            n_err++; $display("FAIL flush_with_pixel: got ov %b word %h addr %h want 1 0c0a 000", a_ov, a_word, a_addr);
        end
        tick();
        a_flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (a_ov !== 1'b0) begin n_err++; $display("FAIL flush_empty%0d: got ov %b want 0", c, a_ov); end
        end
        a_flush = 1'b0;
    endtask

    task automatic test_reset_in_emit();
        do_reset();
        a_ordy = 1'b1;
        for (int i = 0; i < 8; i++) send(0, i[1:0], 1'b0);
        tick();
        a_ordy = 1'b0;
        for (int i = 0; i < 8; i++) send(0, i[1:0], 1'b0);
        n_cmp++;
        if (a_ov !== 1'b1 || a_addr !== 12'h001) begin
            n_err++; $display("FAIL rst_emit_pre: got ov %b addr %h want 1 001", a_ov, a_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (a_ov !== 1'b0 || a_addr !== 12'h0 || a_inr !== 1'b1 || a_word !== 16'h0) begin
            n_err++; $display("FAIL rst_emit_post: got ov %b addr %h inReady %b word %h want 0 000 1 0000", a_ov, a_addr, a_inr, a_word);
        end
        a_ordy = 1'b1;
        send(0, 2'b01, 1'b0);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        n_cmp++;
        if (a_ov !== 1'b1 || a_word !== 16'h0001 || a_addr !== 12'h0) begin
            n_err++; $display("FAIL rst_emit_first: got ov %b word %h addr %h want 1 0001 000", a_ov, a_word, a_addr);
        end
        tick();
    endtask

    task automatic test_addr_wrap();
        logic [17:0] e;
        int start, fd0;
        do_reset();
        b_ordy = 1'b1;
        start = b_xfer.size();
        fd0 = b_fd_cnt;
        for (int i = 0; i < 48; i++) send(1, i[1:0], 1'b0);
        for (int t = 0; t < 20 && b_fd_cnt == fd0; t++) tick();
        repeat (3) tick();
        n_cmp++;
        if (b_xfer.size() - start != 6) begin
            n_err++; $display("FAIL wrap_word_count: got %0d want 6", b_xfer.size() - start);
        end
        for (int k = 0; k < 6; k++) begin
            if (start + k < b_xfer.size()) begin
                e = b_xfer[start + k];
                n_cmp++;
                if (e !== {2'(k % 4), 16'hCCAA}) begin
                    n_err++; $display("FAIL wrap_word%0d: got addr %0d word %h want addr %0d word ccaa", k, e[17:16], e[15:0], k % 4);
                end
            end
        end
        n_cmp++; if (b_fd_cnt - fd0 != 1) begin n_err++; $display("FAIL wrap_done_pulses: got %0d want 1", b_fd_cnt - fd0); end
        n_cmp++; if (b_addr !== 2'd0) begin n_err++; $display("FAIL wrap_addr_after: got %0d want 0", b_addr); end
    endtask

    task automatic test_single_pixel_frame();
        int fd0;
        do_reset();
        c_ordy = 1'b1;
        fd0 = c_fd_cnt;
        send(2, 2'b10, 1'b0);
        n_cmp++;
        if (c_ov !== 1'b1 || c_word !== 8'h10 || c_addr !== 4'h0) begin
            n_err++; $display("FAIL single_first: got ov %b word %h addr %h want 1 10 0", c_ov, c_word, c_addr);
        end
        send(2, 2'b01, 1'b0);
        n_cmp++;
        if (c_ov !== 1'b1 || c_word !== 8'h01 || c_addr !== 4'h0) begin
            n_err++; $display("FAIL single_second: got ov %b word %h addr %h want 1 01 0", c_ov, c_word, c_addr);
        end
        repeat (4) tick();
        n_cmp++; if (c_fd_cnt - fd0 != 2) begin n_err++; $display("FAIL single_done_pulses: got %0d want 2", c_fd_cnt - fd0); end
    endtask

    initial begin
        rst = 1'b1;
        a_pv = 1'b0; a_bits = 2'b00; a_flush = 1'b0; a_ordy = 1'b0;
        b_pv = 1'b0; b_bits = 2'b00; b_flush = 1'b0; b_ordy = 1'b0;
        c_pv = 1'b0; c_bits = 2'b00; c_flush = 1'b0; c_ordy = 1'b0;
        test_reset();
        test_frame();
        test_backpressure();
        test_flush();
        test_flush_same_cycle();
        test_reset_in_emit();
        test_addr_wrap();
        test_single_pixel_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
